// File: rtl/bank_accounter_if.sv
// Agent-side bus for bank_accounter: write snoop, read index and per-reader bank select.
// Latency: none of its own. The interface only carries wires.
// Backpressure: none. Enables are qualifiers only, and no ready signal exists.
// Ports: wren/wraddr (write agents), rden/rdaddr (read agents), bank_select (result),
//        wr_coll_cnt (only when BANK_ACCOUNTER_STATS_EN is defined).
interface bank_accounter_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = 2
);
    logic [NB_WRAGENT-1:0]              wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
    logic [NB_RDAGENT-1:0]              rden;
    logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select;
`ifdef BANK_ACCOUNTER_STATS_EN
    logic [15:0]                        wr_coll_cnt;
`endif

    // The master side is made up of the agents and the read switch.
    modport master (
        output wren, wraddr, rden, rdaddr,
`ifdef BANK_ACCOUNTER_STATS_EN
        input  wr_coll_cnt,
`endif
        input  bank_select
    );

    // The slave side is the accounter itself.
    modport slave (
        input  wren, wraddr, rden, rdaddr,
`ifdef BANK_ACCOUNTER_STATS_EN
        output wr_coll_cnt,
`endif
        output bank_select
    );
endinterface

// File: rtl/bank_accounter.sv
// Per-address record of the write bank holding the newest data. It drives bank_select for each read agent.
// Latency: the read is combinational (0 cycles). A write becomes visible 1 clock later. There is no read-during-write bypass.
// Backpressure: none. Every write is absorbed in the cycle it arrives.
// Ports: aclk, aresetn (async, active-low), bus (bank_accounter_if.slave).
// Optional: define BANK_ACCOUNTER_STATS_EN to add the saturating wr_coll_cnt collision counter.
module bank_accounter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int NB_WRAGENT      = 2,
    parameter int NB_RDAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int BANK_WIDTH      = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int SELECT_WIDTH    = BANK_WIDTH + WRITE_COLLISION
) (
    input  logic               aclk,
    input  logic               aresetn,
    bank_accounter_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Each entry is {coll, bank}. The coll bit exists only when WRITE_COLLISION is set.
    logic [SELECT_WIDTH-1:0] tbl [DEPTH];

    // win: no higher-indexed agent writes the same address this cycle, so this agent's id is stored.
    // dup: some other agent writes the same address this cycle.
    logic [NB_WRAGENT-1:0]   win;
    logic [NB_WRAGENT-1:0]   dup;
    logic [SELECT_WIDTH-1:0] wr_entry [NB_WRAGENT];

    always_comb begin
        win = '0;
        dup = '0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            win[i] = bus.wren[i];
            for (int j = 0; j < NB_WRAGENT; j++) begin
                if (j != i && bus.wren[i] && bus.wren[j] &&
                    bus.wraddr[j*ADDR_WIDTH +: ADDR_WIDTH] == bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    dup[i] = 1'b1;
                    if (j > i) begin
                        win[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NB_WRAGENT; i++) begin
            wr_entry[i] = SELECT_WIDTH'(i);
            if (WRITE_COLLISION != 0) begin
                wr_entry[i][SELECT_WIDTH-1] = dup[i];
            end
        end
    end

    // At most one winner exists per address, so the indices written in one cycle never overlap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int a = 0; a < DEPTH; a++) begin
                tbl[a] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (win[i]) begin
                    tbl[bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_entry[i];
                end
            end
        end
    end

    // The read path returns the pre-update entry when a read and a write hit the same address in one cycle.
    always_comb begin
        bus.bank_select = '0;
        for (int r = 0; r < NB_RDAGENT; r++) begin
            bus.bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = tbl[bus.rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    // rden does not gate the select. The read switch qualifies its own data path.
    logic unused_rden;
    assign unused_rden = ^bus.rden;

`ifdef BANK_ACCOUNTER_STATS_EN
    // The counter adds one per cycle that contains any same-address multi-write, and it saturates at all-ones.
    logic [15:0] coll_cnt;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            coll_cnt <= '0;
        end else if (|dup && coll_cnt != 16'hFFFF) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end
    assign bus.wr_coll_cnt = coll_cnt;
`endif
endmodule

// File: tb/tb_bank_accounter.sv
// Directed bench for bank_accounter: reset state, bank tracking, collisions, read-during-write, async reset.
// Latency: the bench expects bank_select to be combinational and a write to become visible one clock after it is issued.
// Backpressure: not applicable.
module tb_bank_accounter;
    localparam int AW = 8;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int SW = 2;

    logic aclk;
    logic aresetn;
    int   errors = 0;
    int   checks = 0;

    bank_accounter_if #(.ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .SELECT_WIDTH(SW)) bus ();

    bank_accounter #(
        .ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .WRITE_COLLISION(1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] sel(input int r);
        return bus.bank_select[r*SW +: SW];
    endfunction

    // Hold the inputs across one rising edge, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1);
        bus.wren   = en;
        bus.wraddr = {a1, a0};
    endtask

    task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
        bus.rden   = 2'b11;
        bus.rdaddr = {a1, a0};
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        wr(2'b00, 8'h00, 8'h00);
        bus.rden   = 2'b00;
        bus.rdaddr = '0;

        // Reset state.
        rd(8'h10, 8'hFF);
        check("reset_sel0", 32'(sel(0)), 32'h0);
        check("reset_sel1", 32'(sel(1)), 32'h0);
`ifdef BANK_ACCOUNTER_STATS_EN
        check("reset_cnt", 32'(bus.wr_coll_cnt), 32'h0);
`endif
        #11 aresetn = 1'b1;
        tick();

        // Agent 0 writes 10, and then agent 1 writes 10.
        wr(2'b01, 8'h10, 8'h00);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        rd(8'h10, 8'h10);
        check("wr0_0x10", 32'(sel(0)), 32'h0);
        wr(2'b10, 8'h00, 8'h10);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        rd(8'h10, 8'h10);
        check("wr1_0x10_r0", 32'(sel(0)), 32'h1);
        check("wr1_0x10_r1", 32'(sel(1)), 32'h1);
        tick();
        check("hold_0x10", 32'(sel(0)), 32'h1);

        // A collision at 22 stores coll=1 with bank 1. A later single write clears coll.
        wr(2'b11, 8'h22, 8'h22);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        rd(8'h22, 8'h22);
        check("coll_0x22_r0", 32'(sel(0)), 32'h3);
        check("coll_0x22_r1", 32'(sel(1)), 32'h3);
`ifdef BANK_ACCOUNTER_STATS_EN
        check("cnt_after_coll", 32'(bus.wr_coll_cnt), 32'h1);
`endif
        wr(2'b01, 8'h22, 8'h00);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        rd(8'h22, 8'h10);
        check("coll_clear_0x22", 32'(sel(0)), 32'h0);
        check("other_addr_0x10", 32'(sel(1)), 32'h1);

        // A same-cycle read and write at 30 returns the old value, and the new value appears on the next cycle.
        rd(8'h30, 8'h30);
        wr(2'b10, 8'h00, 8'h30);
        #1;
        check("rdw_old_0x30", 32'(sel(0)), 32'h0);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        #1;
        check("rdw_new_0x30", 32'(sel(0)), 32'h1);

        // Writes to different addresses in the same cycle update independently and set no coll bit.
        wr(2'b11, 8'h40, 8'h41);
        tick();
        wr(2'b00, 8'h00, 8'h00);
        rd(8'h40, 8'h41);
        check("indep_0x40", 32'(sel(0)), 32'h0);
        check("indep_0x41", 32'(sel(1)), 32'h1);
`ifdef BANK_ACCOUNTER_STATS_EN
        check("cnt_unchanged", 32'(bus.wr_coll_cnt), 32'h1);

        // The counter saturates after many colliding cycles.
        wr(2'b11, 8'h50, 8'h50);
        for (int k = 0; k < 65540; k++) begin
            @(posedge aclk);
        end
        #1;
        check("cnt_saturated", 32'(bus.wr_coll_cnt), 32'hFFFF);
`endif

        // An async reset asserted mid-cycle clears the table (and the counter) at once.
        wr(2'b11, 8'h60, 8'h61);
        rd(8'h22, 8'h41);
        check("pre_rst_0x41", 32'(sel(1)), 32'h1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("async_rst_0x22", 32'(sel(0)), 32'h0);
        check("async_rst_0x41", 32'(sel(1)), 32'h0);
`ifdef BANK_ACCOUNTER_STATS_EN
        check("async_rst_cnt", 32'(bus.wr_coll_cnt), 32'h0);
`endif
        tick();
        rd(8'h60, 8'h61);
        check("rst_lost_0x61", 32'(sel(1)), 32'h0);
        wr(2'b00, 8'h00, 8'h00);
        #3 aresetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
